// File: rtl/seg2num.sv
// seg2num -- two-digit active-low 7-segment receiver.
//
// Samples the segment word every clock, waits until a pattern has been
// stable for STABLE_CYCLES consecutive samples, then decodes each digit to
// a hex nibble (or flags it as dash / illegal) and publishes the result
// together with a one-cycle o_valid pulse.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept (1..255)
// Ports
//   i_clock   system clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_enable  decoding enable
//   i_SEG     {dp1, g1..a1, dp0, g0..a0}, 0 = segment on
//   o_hex     {digit1, digit0} nibbles of the last accepted pattern
//   o_num     10*digit1 + digit0 when o_dec_ok, else 0
//   o_dec_ok  both digits legal and <= 9
//   o_dash    per digit: pattern was '-'
//   o_error   per digit: pattern was not 0-F or '-'
//   o_DP      per digit: decimal point lit (active-high)
//   o_valid   one-cycle pulse on each newly accepted pattern
module seg2num #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_SEG,
  output logic [7:0]  o_hex,
  output logic [7:0]  o_num,
  output logic        o_dec_ok,
  output logic [1:0]  o_dash,
  output logic [1:0]  o_error,
  output logic [1:0]  o_DP,
  output logic        o_valid
);

  localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRACK,
    S_LOCK
  } state_t;

  // Returns {error, dash, nibble} for one g..a pattern.
  function automatic logic [5:0] decode_digit(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'b10_0000;
    case (pat)
      7'b1000000: r = {2'b00, 4'h0};
      7'b1111001: r = {2'b00, 4'h1};
      7'b0100100: r = {2'b00, 4'h2};
      7'b0110000: r = {2'b00, 4'h3};
      7'b0011001: r = {2'b00, 4'h4};
      7'b0010010: r = {2'b00, 4'h5};
      7'b0000010: r = {2'b00, 4'h6};
      7'b1111000: r = {2'b00, 4'h7};
      7'b0000000: r = {2'b00, 4'h8};
      7'b0010000: r = {2'b00, 4'h9};
      7'b0001000: r = {2'b00, 4'hA};
      7'b0000011: r = {2'b00, 4'hB};
      7'b1000110: r = {2'b00, 4'hC};
      7'b0100001: r = {2'b00, 4'hD};
      7'b0000110: r = {2'b00, 4'hE};
      7'b0001110: r = {2'b00, 4'hF};
      SEG_DASH:   r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [15:0] s_seg;
  logic [15:0] latched, latched_nxt;
  logic        have_latch, have_latch_nxt;
  logic [7:0]  run, run_nxt, run_step;
  logic        accept;

  logic [5:0]  dec1, dec0;
  logic        ok1, ok0, dec_ok;
  logic [7:0]  num_calc;

  // Run length seen with the incoming sample, saturating at RUN_MAX.
  always_comb begin
    if (i_SEG == s_seg) begin
      run_step = (run >= RUN_MAX) ? RUN_MAX : run + 8'd1;
    end else begin
      run_step = 8'd1;
    end
  end

  always_comb begin
    state_nxt      = state;
    run_nxt        = run;
    latched_nxt    = latched;
    have_latch_nxt = have_latch;
    accept         = 1'b0;
    case (state)
      S_IDLE: begin
        run_nxt        = '0;
        latched_nxt    = '0;
        have_latch_nxt = 1'b0;
        if (i_enable) begin
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        run_nxt = run_step;
        if (!i_enable) begin
          state_nxt = S_IDLE;
        end else if (run == RUN_MAX && (!have_latch || s_seg != latched)) begin
          state_nxt      = S_LOCK;
          accept         = 1'b1;
          latched_nxt    = s_seg;
          have_latch_nxt = 1'b1;
        end
      end
      S_LOCK: begin
        run_nxt = run_step;
        if (!i_enable) begin
          state_nxt = S_IDLE;
        end else if (i_SEG != latched) begin
          // Leaving LOCK restarts the count at 1 even if s_seg already
          // held this sample, so the new pattern needs a full fresh run.
          state_nxt = S_TRACK;
          run_nxt   = 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      s_seg      <= '1;
      run        <= '0;
      latched    <= '0;
      have_latch <= 1'b0;
    end else begin
      state      <= state_nxt;
      s_seg      <= i_SEG;
      run        <= run_nxt;
      latched    <= latched_nxt;
      have_latch <= have_latch_nxt;
    end
  end

  // Decode works on the registered sample so no path reaches the outputs
  // from i_SEG.
  always_comb begin
    dec1     = decode_digit(s_seg[14:8]);
    dec0     = decode_digit(s_seg[6:0]);
    ok1      = ~dec1[5] & ~dec1[4] & (dec1[3:0] <= 4'd9);
    ok0      = ~dec0[5] & ~dec0[4] & (dec0[3:0] <= 4'd9);
    dec_ok   = ok1 & ok0;
    num_calc = ({4'b0, dec1[3:0]} << 3) + ({4'b0, dec1[3:0]} << 1)
             + {4'b0, dec0[3:0]};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_hex    <= '0;
      o_num    <= '0;
      o_dec_ok <= 1'b0;
      o_dash   <= '0;
      o_error  <= '0;
      o_DP     <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= accept;
      if (accept) begin
        o_hex    <= {dec1[3:0], dec0[3:0]};
        o_num    <= dec_ok ? num_calc : 8'd0;
        o_dec_ok <= dec_ok;
        o_dash   <= {dec1[4], dec0[4]};
        o_error  <= {dec1[5], dec0[5]};
        o_DP     <= {~s_seg[15], ~s_seg[7]};
      end
    end
  end

endmodule
